// File: rtl/xed_decoder_9_pkg.sv
// ============================================================================
//  Module      : xed_pkg
//  Description : Shared types, constants and the CRC-ATM byte step for XED.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package xed_pkg;

    localparam logic [7:0] CRC_INIT = 8'hFF;
    localparam logic [7:0] CRC_POLY = 8'h07;
    localparam int         N_CHIPS  = 8;
    localparam int         N_LANES  = 9;

    typedef enum logic [1:0] {
        ST_CLEAN       = 2'd0,
        ST_CORRECTED   = 2'd1,
        ST_PARITY_ONLY = 2'd2,
        ST_DUE         = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_EVAL   = 3'd2,
        S_RECON  = 3'd3,
        S_VERIFY = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // One byte through the MSB-first CRC register, no final inversion.
    function automatic logic [7:0] crc_atm_byte(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/xed_decoder_9_if.sv
// ============================================================================
//  Module      : xed_decoder_9_if
//  Description : Codeword-in / corrected-data-out bundle of the XED decoder.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface xed_decoder_9_if
    import xed_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0][127:0]      chip_data;
    logic [7:0][7:0]        chip_crc;
    logic [63:0]            xor_parity_group0;
    logic [63:0]            xor_parity_group1;
    logic [7:0]             xor_parity_crc;
    logic                   out_valid;
    logic                   out_ready;
    logic [7:0][127:0]      out_chip_data;
    status_e                out_status;
    logic [2:0]             out_bad_chip;
    logic [CNT_W-1:0]       cnt_corrected;
    logic [CNT_W-1:0]       cnt_due;

    modport master (
        output in_valid, chip_data, chip_crc, xor_parity_group0, xor_parity_group1,
               xor_parity_crc, out_ready,
        input  in_ready, out_valid, out_chip_data, out_status, out_bad_chip,
               cnt_corrected, cnt_due
    );

    modport slave (
        input  in_valid, chip_data, chip_crc, xor_parity_group0, xor_parity_group1,
               xor_parity_crc, out_ready,
        output in_ready, out_valid, out_chip_data, out_status, out_bad_chip,
               cnt_corrected, cnt_due
    );
endinterface

`default_nettype wire

// File: rtl/xed_decoder_9_crc.sv
// ============================================================================
//  Module      : crc_atm_serial
//  Description : Byte-serial CRC-ATM lane with init/enable and inverted outputs.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module crc_atm_serial
    import xed_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       init_i,
    input  wire logic       en_i,
    input  wire logic [7:0] byte_i,
    output logic      [7:0] crc_final_o,
    output logic      [7:0] crc_next_final_o
);
    logic [7:0] crc_q;
    logic [7:0] crc_d;

    assign crc_d = crc_atm_byte(crc_q, byte_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= CRC_INIT;
        end else if (init_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc_d;
        end
    end

    assign crc_final_o      = ~crc_q;
    // Result as if the current byte were already absorbed; used on the last VERIFY byte.
    assign crc_next_final_o = ~crc_d;

endmodule

`default_nettype wire

// File: rtl/xed_decoder_9.sv
// ============================================================================
//  Module      : xed_decoder_9
//  Description : XED receive checker: nine CRC lanes, single-chip rebuild, verify.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module xed_decoder_9
    import xed_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  wire logic       clk,
    input  wire logic       rst_n,
    xed_decoder_9_if.slave  bus
);
    state_e             state_q;
    logic [3:0]         cnt_q;
    logic [7:0][127:0]  data_q;
    logic [7:0][7:0]    crc_q;
    logic [127:0]       par_q;
    logic [7:0]         pcrc_q;
    logic [2:0]         k_q;
    status_e            status_q;
    logic [2:0]         bad_q;
    logic               out_valid_q;
    logic               in_ready_q;
    logic [CNT_W-1:0]   cntc_q;
    logic [CNT_W-1:0]   cntd_q;

    logic               accept;
    logic [8:0]         lane_init;
    logic [8:0]         lane_en;
    logic [8:0][7:0]    lane_byte;
    logic [8:0][7:0]    lane_final;
    logic [8:0][7:0]    lane_next;
    logic [7:0]         chip_mm;
    logic               par_mm;
    logic               one_mm;
    logic [2:0]         low_idx;
    logic [127:0]       xor_all;
    logic [127:0]       rebuilt;
    logic               verify_ok;

    assign accept = (state_q == S_IDLE) && bus.in_valid && in_ready_q;

    assign lane_init = {9{accept}}
                     | ((state_q == S_RECON)  ? (9'(1) << k_q) : 9'd0);
    assign lane_en   = {9{state_q == S_CHECK}}
                     | ((state_q == S_VERIFY) ? (9'(1) << k_q) : 9'd0);

    always_comb begin
        for (int i = 0; i < N_CHIPS; i++) begin
            lane_byte[i] = data_q[i][{cnt_q, 3'b000} +: 8];
        end
        lane_byte[8] = par_q[{cnt_q, 3'b000} +: 8];
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_lane
        crc_atm_serial u_lane (
            .clk              (clk),
            .rst_n            (rst_n),
            .init_i           (lane_init[i]),
            .en_i             (lane_en[i]),
            .byte_i           (lane_byte[i]),
            .crc_final_o      (lane_final[i]),
            .crc_next_final_o (lane_next[i])
        );
    end

    always_comb begin
        for (int i = 0; i < N_CHIPS; i++) begin
            chip_mm[i] = (lane_final[i] != crc_q[i]);
        end
        par_mm  = (lane_final[8] != pcrc_q);
        one_mm  = (chip_mm != 8'd0) && ((chip_mm & (chip_mm - 8'd1)) == 8'd0);
        low_idx = 3'd0;
        for (int i = N_CHIPS - 1; i >= 0; i--) begin
            if (chip_mm[i]) begin
                low_idx = 3'(i);
            end
        end
    end

    // Parity XOR all chips cancels every good chip and leaves the missing one.
    always_comb begin
        xor_all = '0;
        for (int i = 0; i < N_CHIPS; i++) begin
            xor_all = xor_all ^ data_q[i];
        end
        rebuilt = par_q ^ xor_all ^ data_q[k_q];
    end

    assign verify_ok = (lane_next[{1'b0, k_q}] == crc_q[k_q]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            data_q      <= '0;
            crc_q       <= '0;
            par_q       <= '0;
            pcrc_q      <= 8'd0;
            k_q         <= 3'd0;
            status_q    <= ST_CLEAN;
            bad_q       <= 3'd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            cntc_q      <= '0;
            cntd_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        data_q     <= bus.chip_data;
                        crc_q      <= bus.chip_crc;
                        par_q      <= {bus.xor_parity_group1, bus.xor_parity_group0};
                        pcrc_q     <= bus.xor_parity_crc;
                        cnt_q      <= 4'd15;
                        in_ready_q <= 1'b0;
                        state_q    <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        state_q <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    if (chip_mm == 8'd0) begin
                        status_q    <= par_mm ? ST_PARITY_ONLY : ST_CLEAN;
                        bad_q       <= 3'd0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else if (one_mm && !par_mm) begin
                        k_q     <= low_idx;
                        bad_q   <= low_idx;
                        state_q <= S_RECON;
                    end else begin
                        status_q    <= ST_DUE;
                        bad_q       <= low_idx;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_RECON: begin
                    data_q[k_q] <= rebuilt;
                    cnt_q       <= 4'd15;
                    state_q     <= S_VERIFY;
                end
                S_VERIFY: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0) begin
                        status_q    <= verify_ok ? ST_CORRECTED : ST_DUE;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                        if (status_q == ST_CORRECTED && cntc_q != '1) begin
                            cntc_q <= cntc_q + 1'b1;
                        end
                        if (status_q == ST_DUE && cntd_q != '1) begin
                            cntd_q <= cntd_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_chip_data = data_q;
    assign bus.out_status    = status_q;
    assign bus.out_bad_chip  = bad_q;
    assign bus.cnt_corrected = cntc_q;
    assign bus.cnt_due       = cntd_q;

endmodule

`default_nettype wire

// File: doc/xed_decoder_9.md
# xed_decoder_9

Receive-side checker/corrector for the XED scheme. It consumes one codeword per transaction: 8 chips × 16 B data, 8 per-chip CRC-ATM bytes, two 64-bit XOR parity groups and the parity CRC. It recomputes all nine CRCs byte-serially and classifies the error. A single failed chip is rebuilt from parity and the rebuilt data is re-verified. It sits directly downstream of the XED encoder/storage path and feeds corrected data to the read-return logic.

## Interface
- CNT_W, 16, width of saturating event counters
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_valid  in  1  codeword present
- in_ready  out  1  high only in IDLE
- chip0_data..chip7_data  in  128 each  received chip data
- chip0_crc..chip7_crc  in  8 each  stored per-chip CRC
- xor_parity_group0 / xor_parity_group1  in  64 each  stored parity (group0 = bits [63:0] of each chip, group1 = bits [127:64])
- xor_parity_crc  in  8  CRC over {group1, group0}
- out_valid  out  1  result valid (state DONE)
- out_ready  in  1  consumer accepts
- out_chip0_data..out_chip7_data  out  128 each  delivered data
- out_status  out  2  0 CLEAN, 1 CORRECTED, 2 PARITY_ONLY, 3 DUE
- out_bad_chip  out  3  chip index rebuilt or suspected (0 if none)
- cnt_corrected / cnt_due  out  CNT_W each  saturating event counts

## Operation
- CRC-ATM definition:
  - poly 0x07, init 0xFF
  - bytes processed MSB-first, [127:120] down to [7:0]
  - each byte XORed into the register, then 8 shift steps
  - final result inverted
- Accept on in_valid && in_ready. Capture all inputs; byte counter = 15.
- FSM:
  - IDLE → CHECK on accept.
  - CHECK: each cycle, 9 lanes (8 chips + parity) each consume byte[counter]. The counter decrements. At counter 0 → EVAL.
  - EVAL: compare the 9 computed CRCs with the stored CRCs and count mismatches.
    - 0 mismatches → DONE, CLEAN.
    - Only the parity lane mismatches → DONE, PARITY_ONLY.
    - Exactly one chip lane k mismatches (parity ok) → RECON, bad_chip = k.
    - Anything else → DONE, DUE, bad_chip = lowest mismatching chip.
  - RECON: chip k = {group1, group0} XOR the other 7 chips. Reinit lane k to 0xFF; counter = 15 → VERIFY.
  - VERIFY: lane k re-runs 16 bytes. On the last byte, go to DONE with CORRECTED if the final CRC equals chipk_crc, else DUE.
  - DONE: out_valid = 1, outputs held stable. On out_ready → IDLE.
- DUE and PARITY_ONLY deliver data exactly as received. On a DUE after VERIFY, the rebuilt data is delivered.
- Counters update on the output handshake: CORRECTED increments cnt_corrected; DUE increments cnt_due. Both saturate at 2^CNT_W−1.

## Timing
- Reset values:
  - state IDLE, in_ready 1, out_valid 0
  - all data outputs 0, out_status 0, out_bad_chip 0
  - counters 0
- Latency from accepting edge E0 to out_valid high:
  - 17 cycles on CLEAN, PARITY_ONLY or DUE-from-EVAL (CHECK E1–E16, EVAL E17).
  - 34 cycles on the rebuild path (RECON E18, VERIFY E19–E34).
- No overlap: in_ready stays 0 from E0 until the cycle after the output handshake. in_valid while in_ready = 0 is ignored.
- Output handshake in DONE → IDLE at that edge. A new accept is possible at the next edge at the earliest.
- out_ready held low: all outputs hold indefinitely.
- rst_n asserted in any state, including mid-VERIFY: immediate return to reset values. The partial transaction is discarded and no counter update occurs.

## Structure
- Package xed_pkg:
  - CRC_INIT = 8'hFF, CRC_POLY = 8'h07
  - status enum (CLEAN/CORRECTED/PARITY_ONLY/DUE)
  - FSM state enum (IDLE/CHECK/EVAL/RECON/VERIFY/DONE)
  - function crc_atm_byte(crc, byte), shared with the encoder and the bench model
- Sub-module crc_atm_serial: an 8-bit lane register with init / enable / byte input, plus a final-inverted output. Nine instances. VERIFY reuses lane k via a mux on its byte input.

## Test plan
- Clean: chip k data = {16{8'h11·(k+1)}}; CRCs and parity from the package model → CLEAN, data unchanged, out_valid at E0+17.
- Chip 5 data bit 0 flipped → CORRECTED, bad_chip 5, original data restored, out_valid at E0+34, cnt_corrected = 1.
- xor_parity_group1 bit 63 flipped → PARITY_ONLY, data passthrough, counters unchanged.
- Chips 2 and 6 each with one flipped bit → DUE, bad_chip 2, received data passthrough, cnt_due = 1.
- chip3_crc XOR 8'h01 with correct data → rebuilt data equals received, VERIFY fails → DUE, bad_chip 3.
- Hold out_ready = 0 for 10 cycles in DONE → outputs stable, in_ready = 0. Then apply rst_n low during VERIFY → all outputs at reset values, in_ready = 1 after release. Run with CNT_W = 2 for 4 CORRECTED transactions → cnt_corrected saturates at 3.
